// File: rtl/sdram_rw_tester.sv
// Avalon-MM SDRAM read/write tester: writes a generated pattern over a
// word range, reads it back pipelined, compares and reports mismatches.
module sdram_rw_tester #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 24,
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic                  loop_en,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     num_words,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    input  logic                  avm_waitrequest,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      err_count,
    output logic [CNT_W-1:0]      pass_count,
    output logic [ADDR_W-1:0]     err_addr,
    output logic [DATA_W-1:0]     err_exp,
    output logic [DATA_W-1:0]     err_got
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [ADDR_W-1:0] DW_A  = ADDR_W'(DATA_W);
    localparam logic [3:0]        MAX_O = 4'(MAX_OUTST);
    localparam logic [DATA_W-1:0] CHK_E = {(DATA_W/2){2'b10}};
    localparam logic [DATA_W-1:0] CHK_O = {(DATA_W/2){2'b01}};

    logic [2:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic              loop_q, loop_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] num_q, num_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] ret_q, ret_d;
    logic [3:0]        outst_q, outst_d;
    logic              abort_q, abort_d;
    logic [CNT_W-1:0]  errc_q, errc_d;
    logic [CNT_W-1:0]  passc_q, passc_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] eaddr_q, eaddr_d;
    logic [DATA_W-1:0] eexp_q, eexp_d;
    logic [DATA_W-1:0] egot_q, egot_d;

    logic              wr_en, rd_en, wr_acc, rd_acc, rtn, busy_w;
    logic [ADDR_W-1:0] idx_inc;
    logic [DATA_W-1:0] exp_rd;

    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]        m,
        input logic [ADDR_W-1:0] i
    );
        unique case (m)
            2'd0:    pattern = DATA_W'(i);
            2'd1:    pattern = DATA_W'(1) << (i % DW_A);
            2'd2:    pattern = ~DATA_W'(i);
            default: pattern = i[0] ? CHK_O : CHK_E;
        endcase
    endfunction

    assign busy_w  = (state_q == S_WRITE) || (state_q == S_READ) ||
                     (state_q == S_DRAIN);
    assign wr_en   = (state_q == S_WRITE);
    assign rd_en   = (state_q == S_READ) && (outst_q < MAX_O) &&
                     (idx_q < num_q);
    assign wr_acc  = wr_en && !avm_waitrequest;
    assign rd_acc  = rd_en && !avm_waitrequest;
    // Returns with nothing in flight (e.g. while idle) are ignored.
    assign rtn     = avm_readdatavalid && (outst_q != 4'd0);
    assign idx_inc = idx_q + 1'b1;
    assign exp_rd  = pattern(mode_q, ret_q);

    assign avm_write      = wr_en;
    assign avm_read       = rd_en;
    assign avm_address    = (wr_en || rd_en) ? base_q + idx_q : '0;
    assign avm_writedata  = wr_en ? pattern(mode_q, idx_q) : '0;
    assign avm_byteenable = '1;
    assign busy           = busy_w;
    assign done           = (state_q == S_FINISH);
    assign pass           = pass_q;
    assign err_count      = errc_q;
    assign pass_count     = passc_q;
    assign err_addr       = eaddr_q;
    assign err_exp        = eexp_q;
    assign err_got        = egot_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        loop_d  = loop_q;
        base_d  = base_q;
        num_d   = num_q;
        idx_d   = idx_q;
        ret_d   = ret_q;
        abort_d = abort_q;
        errc_d  = errc_q;
        passc_d = passc_q;
        pass_d  = pass_q;
        eaddr_d = eaddr_q;
        eexp_d  = eexp_q;
        egot_d  = egot_q;
        outst_d = outst_q + {3'b000, rd_acc} - {3'b000, rtn};

        if (busy_w && abort) begin
            abort_d = 1'b1;
        end

        if (rtn) begin
            ret_d = ret_q + 1'b1;
            if (avm_readdata != exp_rd) begin
                if (errc_q != '1) begin
                    errc_d = errc_q + 1'b1;
                end
                if (errc_q == '0) begin
                    eaddr_d = base_q + ret_q;
                    eexp_d  = exp_rd;
                    egot_d  = avm_readdata;
                end
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    loop_d  = loop_en;
                    base_d  = base_addr;
                    num_d   = num_words;
                    idx_d   = '0;
                    ret_d   = '0;
                    abort_d = 1'b0;
                    errc_d  = '0;
                    eaddr_d = '0;
                    eexp_d  = '0;
                    egot_d  = '0;
                    pass_d  = 1'b0;
                    if (num_words == '0) begin
                        pass_d  = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        passc_d = '0;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (wr_acc) begin
                    if (idx_inc == num_q) begin
                        idx_d   = '0;
                        state_d = S_READ;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            S_READ: begin
                if (rd_acc) begin
                    if (idx_inc == num_q) begin
                        idx_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            S_DRAIN: begin
                if (outst_q == 4'd0) begin
                    passc_d = passc_q + 1'b1;
                    ret_d   = '0;
                    // An abort arriving in this very cycle still counts.
                    if (loop_q && !abort_q && !abort) begin
                        state_d = S_WRITE;
                    end else begin
                        pass_d  = (errc_q == '0);
                        state_d = S_FINISH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            loop_q  <= 1'b0;
            base_q  <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            ret_q   <= '0;
            outst_q <= '0;
            abort_q <= 1'b0;
            errc_q  <= '0;
            passc_q <= '0;
            pass_q  <= 1'b0;
            eaddr_q <= '0;
            eexp_q  <= '0;
            egot_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            loop_q  <= loop_d;
            base_q  <= base_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            ret_q   <= ret_d;
            outst_q <= outst_d;
            abort_q <= abort_d;
            errc_q  <= errc_d;
            passc_q <= passc_d;
            pass_q  <= pass_d;
            eaddr_q <= eaddr_d;
            eexp_q  <= eexp_d;
            egot_q  <= egot_d;
        end
    end

endmodule
